// File: rtl/handshake_tx_sequencer.sv
// ---------------------------------------------------------------------------
// handshake_tx_sequencer
//
// Transmitter-side front end for the clock-domain-crossing handshaker.
// A producer in the T_Clock domain pushes words into a small FIFO. The
// sequencer sends those words to the handshaker one at a time. Each word is
// sent as a single-cycle HS_Start pulse while HS_Data is held stable. A new
// start is only issued after the handshaker has dropped HS_Busy.
//
// Optional feature (macro HSTX_TIMEOUT_EN):
//   With the macro defined, a busy watchdog runs in WAIT_DONE. When HS_Busy
//   stays high for TIMEOUT cycles, the sticky Timeout flag sets and the FSM
//   returns to IDLE. The word that was in flight is treated as lost.
//   With the macro undefined, the Timeout port does not exist and WAIT_DONE
//   waits indefinitely.
//
// Ports:
//   T_Clock   in   transmitter-domain clock
//   T_Reset   in   asynchronous reset, active-low
//   In_Data   in   word to enqueue
//   In_Write  in   enqueue strobe, one word per cycle
//   In_Full   out  FIFO full (decoded from Count)
//   Count     out  words queued, excluding the word in flight
//   Clear     in   synchronous flush of the queue and the sticky flags
//   Overflow  out  sticky: a write was dropped because the FIFO was full
//   Idle      out  queue empty, FSM in IDLE and HS_Busy low
//   HS_Data   out  to handshaker T_Data
//   HS_Start  out  to handshaker T_Start, one cycle wide
//   HS_Busy   in   from handshaker T_Busy
//   Timeout   out  sticky busy-timeout flag (HSTX_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module handshake_tx_sequencer #(
    parameter int WID_DATA = 8,
    parameter int DEPTH    = 4,
    parameter int WID_CNT  = 3,
    parameter int TIMEOUT  = 1023
) (
    input  logic                T_Clock,
    input  logic                T_Reset,
    input  logic [WID_DATA-1:0] In_Data,
    input  logic                In_Write,
    output logic                In_Full,
    output logic [WID_CNT-1:0]  Count,
    input  logic                Clear,
    output logic                Overflow,
    output logic                Idle,
    output logic [WID_DATA-1:0] HS_Data,
    output logic                HS_Start,
    input  logic                HS_Busy
`ifdef HSTX_TIMEOUT_EN
    ,
    output logic                Timeout
`endif
);

    localparam int WID_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WID_CNT-1:0] CNT_FULL = WID_CNT'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WID_PTR-1:0]   wr_ptr;
    logic [WID_PTR-1:0]   rd_ptr;
    logic [WID_DATA-1:0]  mem [DEPTH];
    logic                 push;
    logic                 drop;
    logic                 pop;

`ifdef HSTX_TIMEOUT_EN
    localparam int WID_CNT_TO = $clog2(TIMEOUT + 1);
    // When this count is reached with HS_Busy still high, the current cycle
    // is the TIMEOUT-th busy cycle.
    localparam logic [WID_CNT_TO-1:0] TO_LAST = WID_CNT_TO'(TIMEOUT - 1);

    logic [WID_CNT_TO-1:0] to_cnt;
    logic                  to_fire;
`endif

    // Fullness is judged on the registered Count. A write is therefore
    // dropped even in a cycle where a pop frees a slot. Clear has priority
    // over any concurrent write.
    assign push = In_Write && !Clear && (Count != CNT_FULL);
    assign drop = In_Write && !Clear && (Count == CNT_FULL);

    assign In_Full = (Count == CNT_FULL);
    assign Idle    = (Count == '0) && (state_q == IDLE) && !HS_Busy;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
`ifdef HSTX_TIMEOUT_EN
        to_fire = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if ((Count != '0) && !HS_Busy && !Clear) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            // The handshaker samples HS_Start this cycle and raises busy on
            // the same edge, so there is nothing to wait for here.
            START: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (!HS_Busy) begin
                    state_d = IDLE;
                end
`ifdef HSTX_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    state_d = IDLE;
                    to_fire = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue storage is plain data and needs no reset.
    always_ff @(posedge T_Clock) begin
        if (push) begin
            mem[wr_ptr] <= In_Data;
        end
    end

    always_ff @(posedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            HS_Start <= 1'b0;
            HS_Data  <= '0;
            Overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            HS_Start <= pop;
            // HS_Data only changes on a pop. It therefore holds the last
            // word sent through HS_Start and the whole busy period.
            if (pop) begin
                HS_Data <= mem[rd_ptr];
            end
            // Clear flushes the queue only. A transfer already handed to
            // the handshaker runs to completion.
            if (Clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                Count    <= '0;
                Overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + WID_PTR'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + WID_PTR'(1);
                end
                if (push && !pop) begin
                    Count <= Count + WID_CNT'(1);
                end else if (pop && !push) begin
                    Count <= Count - WID_CNT'(1);
                end
                if (drop) begin
                    Overflow <= 1'b1;
                end
            end
        end
    end

`ifdef HSTX_TIMEOUT_EN
    // WAIT_DONE can only be entered from START, so clearing the counter in
    // START clears it on every entry.
    always_ff @(posedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            to_cnt  <= '0;
            Timeout <= 1'b0;
        end else begin
            if (state_q == START) begin
                to_cnt <= '0;
            end else if ((state_q == WAIT_DONE) && HS_Busy) begin
                to_cnt <= to_cnt + WID_CNT_TO'(1);
            end
            if (Clear) begin
                Timeout <= 1'b0;
            end else if (to_fire) begin
                Timeout <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_handshake_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_handshake_tx_sequencer
//
// Directed bench for handshake_tx_sequencer. A small handshaker model raises
// HS_Busy on the edge that samples HS_Start and holds it for busy_len
// cycles. force_busy can also hold HS_Busy high indefinitely. A monitor logs
// every start pulse and checks two things: that HS_Data holds while busy is
// high, and that no start is issued while busy is high. Timeout tests run
// only when HSTX_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_handshake_tx_sequencer;

    localparam int WID_DATA = 8;
    localparam int DEPTH    = 4;
    localparam int WID_CNT  = 3;
    localparam int TIMEOUT  = 15;

    logic                T_Clock = 1'b0;
    logic                T_Reset;
    logic [WID_DATA-1:0] In_Data;
    logic                In_Write;
    logic                In_Full;
    logic [WID_CNT-1:0]  Count;
    logic                Clear;
    logic                Overflow;
    logic                Idle;
    logic [WID_DATA-1:0] HS_Data;
    logic                HS_Start;
    logic                HS_Busy;
`ifdef HSTX_TIMEOUT_EN
    logic                Timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt;
    int busy_len;
    bit force_busy;
    int peak;

    logic [WID_DATA-1:0] sent_q [$];
    logic [WID_DATA-1:0] held;
    logic                prev_busy;
    logic [WID_DATA-1:0] w;

    handshake_tx_sequencer #(
        .WID_DATA (WID_DATA),
        .DEPTH    (DEPTH),
        .WID_CNT  (WID_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .T_Clock  (T_Clock),
        .T_Reset  (T_Reset),
        .In_Data  (In_Data),
        .In_Write (In_Write),
        .In_Full  (In_Full),
        .Count    (Count),
        .Clear    (Clear),
        .Overflow (Overflow),
        .Idle     (Idle),
        .HS_Data  (HS_Data),
        .HS_Start (HS_Start),
`ifdef HSTX_TIMEOUT_EN
        .HS_Busy  (HS_Busy),
        .Timeout  (Timeout)
`else
        .HS_Busy  (HS_Busy)
`endif
    );

    always #5 T_Clock = ~T_Clock;

    // Handshaker model: busy rises on the edge that samples HS_Start.
    assign HS_Busy = force_busy || (busy_cnt != 0);

    always @(posedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            busy_cnt <= 0;
        end else if (HS_Start) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Start/stability monitor
    always @(posedge T_Clock) begin
        if (!T_Reset) begin
            held      <= '0;
            prev_busy <= 1'b0;
        end else begin
            if (HS_Start) begin
                check("start_vs_busy", 32'(prev_busy), 32'd0);
                sent_q.push_back(HS_Data);
                held <= HS_Data;
            end else if (HS_Busy) begin
                check("data_hold", 32'(HS_Data), 32'(held));
            end
            prev_busy <= HS_Busy;
        end
    end

    task automatic tick();
        @(posedge T_Clock);
        #1;
        if (int'(Count) > peak) peak = int'(Count);
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int cyc = 0;
        while ((sent_q.size() < n || !Idle) && cyc < budget) begin
            tick();
            cyc++;
        end
        check(tag, 32'(sent_q.size()), 32'(n));
    endtask

    task automatic write_word(input logic [WID_DATA-1:0] d);
        In_Data  = d;
        In_Write = 1'b1;
        tick();
        In_Write = 1'b0;
    endtask

    initial begin
        T_Reset    = 1'b0;
        In_Data    = '0;
        In_Write   = 1'b0;
        Clear      = 1'b0;
        force_busy = 1'b0;
        busy_len   = 6;
        peak       = 0;
        repeat (2) @(posedge T_Clock);
        #1;

        // Reset state
        check("rst_start", 32'(HS_Start), 32'd0);
        check("rst_data",  32'(HS_Data),  32'd0);
        check("rst_count", 32'(Count),    32'd0);
        check("rst_full",  32'(In_Full),  32'd0);
        check("rst_ovf",   32'(Overflow), 32'd0);
        check("rst_idle",  32'(Idle),     32'd1);
        T_Reset = 1'b1;
        tick();

        // Single word A5, busy 6 cycles
        write_word(8'hA5);
        check("t1_cnt1",    32'(Count),    32'd1);
        check("t1_nostart", 32'(HS_Start), 32'd0);
        tick();
        check("t1_start",   32'(HS_Start), 32'd1);
        check("t1_data",    32'(HS_Data),  32'hA5);
        check("t1_cnt0",    32'(Count),    32'd0);
        tick();
        check("t1_pulse1",  32'(HS_Start), 32'd0);
        check("t1_busy",    32'(HS_Busy),  32'd1);
        begin
            int n = 0;
            while (HS_Busy && n < 20) begin
                tick();
                n++;
            end
            check("t1_busy_len", 32'(n), 32'd6);
        end
        check("t1_idle_lag", 32'(Idle),    32'd0);
        tick();
        check("t1_idle",     32'(Idle),    32'd1);
        check("t1_held",     32'(HS_Data), 32'hA5);
        check("t1_nstart",   32'(sent_q.size()), 32'd1);

        // Burst of four words, busy 5 cycles each
        sent_q.delete();
        busy_len = 5;
        peak     = 0;
        for (int i = 0; i < 4; i++) begin
            write_word(8'(i + 1));
        end
        wait_done("t2_nstart", 4, 200);
        for (int i = 0; i < 4; i++) begin
            w = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            check("t2_order", 32'(w), 32'(i + 1));
        end
        check("t2_peak", 32'(peak), 32'd3);

        // Six writes while busy is held: saturation and overflow
        sent_q.delete();
        busy_len   = 2;
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            write_word(8'(8'h10 + i));
            if (i == 3) begin
                check("t3_cnt4",  32'(Count),    32'd4);
                check("t3_full",  32'(In_Full),  32'd1);
                check("t3_noovf", 32'(Overflow), 32'd0);
            end
        end
        check("t3_cnt_sat", 32'(Count),    32'd4);
        check("t3_full2",   32'(In_Full),  32'd1);
        check("t3_ovf",     32'(Overflow), 32'd1);
        check("t3_nostart", 32'(sent_q.size()), 32'd0);
        force_busy = 1'b0;
        wait_done("t3_nstart", 4, 200);
        for (int i = 0; i < 4; i++) begin
            w = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            check("t3_order", 32'(w), 32'(8'h10 + i));
        end
        check("t3_ovf_sticky", 32'(Overflow), 32'd1);
        check("t3_notfull",    32'(In_Full),  32'd0);

        // Clear during WAIT_DONE with two words queued
        sent_q.delete();
        busy_len = 6;
        write_word(8'h21);
        write_word(8'h22);
        write_word(8'h23);
        check("t4_cnt2",  32'(Count),   32'd2);
        check("t4_busy",  32'(HS_Busy), 32'd1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("t4_clr_cnt",  32'(Count),    32'd0);
        check("t4_clr_ovf",  32'(Overflow), 32'd0);
        check("t4_inflight", 32'(HS_Busy),  32'd1);
        wait_done("t4_nstart", 1, 60);
        repeat (5) tick();
        check("t4_only1", 32'(sent_q.size()), 32'd1);
        check("t4_data",  32'(HS_Data),       32'h21);

        // Asynchronous reset during START
        sent_q.delete();
        write_word(8'h5C);
        tick();
        check("t5_start", 32'(HS_Start), 32'd1);
        #1;
        T_Reset = 1'b0;
        #1;
        check("t5_rst_start", 32'(HS_Start), 32'd0);
        check("t5_rst_cnt",   32'(Count),    32'd0);
        check("t5_rst_data",  32'(HS_Data),  32'd0);
        check("t5_rst_idle",  32'(Idle),     32'd1);
        repeat (2) @(posedge T_Clock);
        #1;
        T_Reset = 1'b1;
        sent_q.delete();
        repeat (8) tick();
        check("t5_nostart", 32'(sent_q.size()), 32'd0);
        write_word(8'h77);
        wait_done("t5_nstart", 1, 60);
        w = (sent_q.size() > 0) ? sent_q[0] : 8'hxx;
        check("t5_word", 32'(w), 32'h77);

`ifdef HSTX_TIMEOUT_EN
        // Busy stuck high after the first start
        sent_q.delete();
        busy_len = 2;
        write_word(8'h31);
        write_word(8'h32);
        check("t6_start", 32'(HS_Start), 32'd1);
        force_busy = 1'b1;
        repeat (15) tick();
        check("t6_no_to",  32'(Timeout), 32'd0);
        tick();
        check("t6_to",     32'(Timeout), 32'd1);
        check("t6_cnt",    32'(Count),   32'd1);
        check("t6_idle",   32'(Idle),    32'd0);
        repeat (10) tick();
        check("t6_held_off", 32'(sent_q.size()), 32'd1);
        force_busy = 1'b0;
        wait_done("t6_nstart", 2, 60);
        w = (sent_q.size() > 1) ? sent_q[1] : 8'hxx;
        check("t6_word2",  32'(w),       32'h32);
        check("t6_sticky", 32'(Timeout), 32'd1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("t6_clr", 32'(Timeout), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
